uart_parity_gen: RTL and testbench

Registered parity-bit generator for the UART transmitter. It is 16550-style, driven by line-control fields WLS/EPS/PEN/SP. On a load strobe it computes the parity of the active character bits of tx_data. It holds the parity bit for the TX shift FSM until the next load.

---
 rtl/uart_parity_gen.sv | 57 +++++
 tb/tb_uart_parity_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_parity_gen.sv
// Registered 16550-style parity generator for the UART transmitter.
// Captures the parity of the active character bits on each tx_load strobe and holds it.
module uart_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_load,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        WLS,
  input  logic              EPS,
  input  logic              PEN,
  input  logic              SP,
  output logic              parity,
  output logic              parity_valid
);

  logic [DATA_W-1:0] mask_c;
  logic              x_c;
  logic              parity_d;
  logic              parity_q;
  logic              valid_q;

  // Character length is 5 + WLS bits; everything above it is ignored.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      mask_c[i] = (i <= (4 + int'(WLS)));
    end
  end

  assign x_c = ^(tx_data & mask_c);

  always_comb begin
    parity_d = 1'b0;
    if (!PEN)      parity_d = 1'b0;
    else if (SP)   parity_d = ~EPS;
    else if (EPS)  parity_d = x_c;
    else           parity_d = ~x_c;
  end

  // parity_valid: sticky flag, set by the first load after reset; parity is
  // valid whenever it is 1 and is replaced on every tx_load edge (no backpressure).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
    end else if (tx_load) begin
      parity_q <= parity_d;
      valid_q  <= 1'b1;
    end
  end

  assign parity       = parity_q;
  assign parity_valid = valid_q;

endmodule

// File: tb/tb_uart_parity_gen.sv
// Scoreboard bench for uart_parity_gen: directed vectors with hand-computed parity,
// a mid-run asynchronous reset, a hold check and a random sweep against a reference model.
module tb_uart_parity_gen;

  localparam int W = 1;

  logic       clk;
  logic       rst;
  logic       tx_load;
  logic [7:0] tx_data;
  logic [1:0] WLS;
  logic       EPS;
  logic       PEN;
  logic       SP;
  logic       parity;
  logic       parity_valid;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic exp_par = 1'b0;
  logic exp_vld = 1'b0;

  uart_parity_gen #(.DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_load      (tx_load),
    .tx_data      (tx_data),
    .WLS          (WLS),
    .EPS          (EPS),
    .PEN          (PEN),
    .SP           (SP),
    .parity       (parity),
    .parity_valid (parity_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_par(input logic [7:0] d, input logic [1:0] w,
                                   input logic e, input logic p, input logic s);
    int   n;
    logic x;
    n = 5 + int'(w);
    x = 1'b0;
    for (int i = 0; i < n; i++) x = x ^ d[i];
    if (!p)      return 1'b0;
    else if (s)  return ~e;
    else if (e)  return x;
    else         return ~x;
  endfunction

  // driver
  task automatic load(input logic [7:0] d, input logic [1:0] w, input logic e,
                      input logic p, input logic s, input logic exp_bit);
    @(negedge clk);
    tx_data = d; WLS = w; EPS = e; PEN = p; SP = s;
    tx_load = 1'b1;
    exp_q.push_back(exp_bit);
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(posedge rst) begin
    exp_par = 1'b0;
    exp_vld = 1'b0;
  end

  always @(posedge clk) begin
    logic ld;
    logic r;
    ld = tx_load;
    r  = rst;
    #1;
    if (r) begin
      exp_par = 1'b0;
      exp_vld = 1'b0;
    end else if (ld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: load seen with empty queue at %0t", $time);
      end else begin
        exp_par = exp_q.pop_front();
        exp_vld = 1'b1;
      end
    end
    check("mon_parity", parity, exp_par);
    check("mon_valid", parity_valid, exp_vld);
  end

  initial begin
    rst = 1'b1; tx_load = 1'b0; tx_data = '0; WLS = 2'b11; EPS = 1'b1; PEN = 1'b1; SP = 1'b0;
    #1;
    check("reset_parity", parity, 1'b0);
    check("reset_valid", parity_valid, 1'b0);
    idle(3);
    rst = 1'b0;
    idle(3);

    // width masking, even parity, 8'hB5
    load(8'hB5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    load(8'hB5, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    load(8'hB5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    load(8'hB5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    // odd parity
    load(8'hB5, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    load(8'h00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
    // parity disabled and stick parity
    load(8'hB5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    load(8'hB5, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
    load(8'hB5, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    load(8'hB5, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);

    // hold: inputs change without tx_load, result must not move
    load(8'hB5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1);
    tx_data = 8'h01;
    idle(5);
    load(8'h01, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset mid-cycle, with tx_load active while held
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_parity", parity, 1'b0);
    check("async_rst_valid", parity_valid, 1'b0);
    tx_data = 8'h00; WLS = 2'b11; EPS = 1'b0; PEN = 1'b1; SP = 1'b0;
    tx_load = 1'b1;
    idle(2);
    tx_load = 1'b0;
    rst = 1'b0;
    idle(4);

    // back-to-back loads
    @(negedge clk);
    tx_load = 1'b1;
    tx_data = 8'h03; WLS = 2'b00; EPS = 1'b1; PEN = 1'b1; SP = 1'b0;
    exp_q.push_back(1'b0);
    @(negedge clk);
    tx_data = 8'h07;
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_data = 8'hE0; WLS = 2'b01;
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_load = 1'b0;

    // random sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      tx_data = 8'($urandom_range(0, 255));
      WLS     = 2'($urandom_range(0, 3));
      EPS     = 1'($urandom_range(0, 1));
      PEN     = 1'($urandom_range(0, 1));
      SP      = 1'($urandom_range(0, 1));
      tx_load = 1'($urandom_range(0, 1));
      if (tx_load) exp_q.push_back(ref_par(tx_data, WLS, EPS, PEN, SP));
    end
    @(negedge clk);
    tx_load = 1'b0;
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
